// File: rtl/alu_share_pkg.sv
// Shared definitions for the shared-ALU arbiter: op encodings, FSM states, CC bit positions.
package alu_share_pkg;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

  typedef enum logic [0:0] {
    StIdle,
    StResp
  } state_e;

  // Bit positions inside the {ZF,SF,OF} condition-code vector.
  localparam int unsigned CC_ZF = 2;
  localparam int unsigned CC_SF = 1;
  localparam int unsigned CC_OF = 0;

  localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/alu64.sv
// Combinational Y86 ALU (add/sub/and/xor) with ZF/SF/OF flag generation.
module alu64
  import alu_share_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              zf,
  output logic              sf,
  output logic              of
);

  localparam int unsigned Msb = DATA_W - 1;

  always_comb begin
    result = '0;
    of     = 1'b0;
    unique case (op)
      ALU_ADD: begin
        result = a + b;
        of     = (a[Msb] == b[Msb]) && (result[Msb] != a[Msb]);
      end
      ALU_SUB: begin
        result = a - b;
        of     = (a[Msb] != b[Msb]) && (result[Msb] != a[Msb]);
      end
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
    endcase
  end

  assign zf = (result == '0);
  assign sf = result[Msb];

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one alu64 among NREQ requesters, with a registered response.
// Optional architectural CC register enabled by defining ALU_SHARE_CC_REG_EN.
module alu_share_arb
  import alu_share_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREQ   = 2,
  parameter int unsigned ID_W   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [2*NREQ-1:0]      req_op,
  input  logic [DATA_W*NREQ-1:0] req_a,
  input  logic [DATA_W*NREQ-1:0] req_b,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [DATA_W-1:0]      resp_result,
  output logic                   resp_zf,
  output logic                   resp_sf,
  output logic                   resp_of,
  output logic [2:0]             cc_out
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     winner;
  logic                found;
  logic                can_accept;
  logic                accept;

  logic [1:0]          op_sel;
  logic [DATA_W-1:0]   a_sel, b_sel;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_zf, alu_sf, alu_of;

  logic [ID_W-1:0]     id_q;
  logic [DATA_W-1:0]   result_q;
  logic                zf_q, sf_q, of_q;

  // Grants are suppressed during reset so nothing is accepted into a flop held in reset.
  assign can_accept = ~rst & ((state_q == StIdle) || ((state_q == StResp) && resp_ready));
  assign accept     = can_accept & found;

  // First valid requester at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!found && req_valid[j] && (((32'(rr_ptr_q) + k) % NREQ) == j)) begin
          found  = 1'b1;
          winner = ID_W'(j);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    op_sel    = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (winner == ID_W'(j)) begin
        req_ready[j] = accept;
        op_sel       = req_op[2*j +: 2];
        a_sel        = req_a[DATA_W*j +: DATA_W];
        b_sel        = req_b[DATA_W*j +: DATA_W];
      end
    end
  end

  alu64 #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a      (a_sel),
    .b      (b_sel),
    .op     (op_sel),
    .result (alu_result),
    .zf     (alu_zf),
    .sf     (alu_sf),
    .of     (alu_of)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StResp;
      end
      StResp: begin
        if (accept) begin
          state_d = StResp;
        end else if (resp_ready) begin
          state_d = StIdle;
        end
      end
    endcase
    if (accept) begin
      rr_ptr_d = (winner == ID_W'(NREQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Response holds its value while the consumer stalls; only an accept reloads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q     <= '0;
      result_q <= '0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else if (accept) begin
      id_q     <= winner;
      result_q <= alu_result;
      zf_q     <= alu_zf;
      sf_q     <= alu_sf;
      of_q     <= alu_of;
    end
  end

  assign resp_valid  = (state_q == StResp);
  assign resp_id     = id_q;
  assign resp_result = result_q;
  assign resp_zf     = zf_q;
  assign resp_sf     = sf_q;
  assign resp_of     = of_q;

`ifdef ALU_SHARE_CC_REG_EN
  logic [2:0] cc_q;

  // Only requester 0 (the execute stage) updates the architectural condition codes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q <= CC_RESET;
    end else if (accept && (winner == '0)) begin
      cc_q[CC_ZF] <= alu_zf;
      cc_q[CC_SF] <= alu_sf;
      cc_q[CC_OF] <= alu_of;
    end
  end

  assign cc_out = cc_q;
`else
  assign cc_out = 3'b000;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: vector table plus contention, backpressure and reset sequences.
module tb_alu_share_arb;
  import alu_share_pkg::*;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned NREQ   = 2;
  localparam int unsigned ID_W   = 2;

`ifdef ALU_SHARE_CC_REG_EN
  localparam bit CcEn = 1'b1;
`else
  localparam bit CcEn = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [2*NREQ-1:0]      req_op;
  logic [DATA_W*NREQ-1:0] req_a;
  logic [DATA_W*NREQ-1:0] req_b;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [ID_W-1:0]        resp_id;
  logic [DATA_W-1:0]      resp_result;
  logic                   resp_zf, resp_sf, resp_of;
  logic [2:0]             cc_out;

  alu_share_arb #(
    .DATA_W (DATA_W),
    .NREQ   (NREQ),
    .ID_W   (ID_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_zf     (resp_zf),
    .resp_sf     (resp_sf),
    .resp_of     (resp_of),
    .cc_out      (cc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned rq;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic        zf;
    logic        sf;
    logic        of;
  } vec_t;

  vec_t        vt[11];
  int          n_vec = 0;
  int          n_err = 0;
  logic [2:0]  cc_model;
  logic [1:0]  exp_rdy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned rq, input logic [1:0] op,
                         input logic [63:0] a, input logic [63:0] b);
    req_op[2*rq +: 2]          = op;
    req_a[DATA_W*rq +: DATA_W] = a;
    req_b[DATA_W*rq +: DATA_W] = b;
  endtask

  initial begin
    vt[0]  = '{0, ALU_ADD, 64'd1, 64'd3, 64'd4, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1, ALU_SUB, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE,
               64'h8000_0000_0000_0001, 1'b0, 1'b1, 1'b1};
    vt[2]  = '{0, ALU_XOR, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'd0, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{1, ALU_AND, 64'hF0, 64'h0F, 64'd0, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{0, ALU_SUB, 64'd546, 64'd7, 64'd539, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{0, ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
               64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1};
    vt[6]  = '{1, ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{0, ALU_SUB, 64'h8000_0000_0000_0000, 64'd1,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{1, ALU_XOR, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF,
               64'hFFFF_FFFF_0000_0000, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{1, ALU_SUB, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0};
    vt[10] = '{0, ALU_AND, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
               64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};

    // Reset state, with both requesters asserting to prove no grant leaks out.
    rst        = 1'b1;
    req_valid  = 2'b11;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    #3;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_id", 64'(resp_id), 64'd0);
    check("rst_resp_result", resp_result, 64'd0);
    check("rst_flags", 64'({resp_zf, resp_sf, resp_of}), 64'd0);
    check("rst_cc_out", 64'(cc_out), CcEn ? 64'h4 : 64'h0);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    cc_model = 3'b100;

    // Single-requester vectors: grant, one-cycle latency, result and flags.
    for (int i = 0; i < 11; i++) begin
      set_req(vt[i].rq, vt[i].op, vt[i].a, vt[i].b);
      req_valid          = '0;
      req_valid[vt[i].rq] = 1'b1;
      resp_ready         = 1'b1;
      exp_rdy            = '0;
      exp_rdy[vt[i].rq]  = 1'b1;
      #1;
      check($sformatf("v%0d_req_ready", i), 64'(req_ready), 64'(exp_rdy));
      tick();
      req_valid = '0;
      if (vt[i].rq == 0) cc_model = {vt[i].zf, vt[i].sf, vt[i].of};
      #1;
      check($sformatf("v%0d_resp_valid", i), 64'(resp_valid), 64'd1);
      check($sformatf("v%0d_resp_id", i), 64'(resp_id), 64'(vt[i].rq));
      check($sformatf("v%0d_result", i), resp_result, vt[i].r);
      check($sformatf("v%0d_flags", i), 64'({resp_zf, resp_sf, resp_of}),
            64'({vt[i].zf, vt[i].sf, vt[i].of}));
      check($sformatf("v%0d_cc_out", i), 64'(cc_out), CcEn ? 64'(cc_model) : 64'd0);
      tick();
      check($sformatf("v%0d_idle", i), 64'(resp_valid), 64'd0);
    end

    // Contention from reset: grants alternate 0,1,0,1 with a result every cycle.
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    set_req(0, ALU_ADD, 64'd10, 64'd1);
    set_req(1, ALU_ADD, 64'd20, 64'd2);
    req_valid  = 2'b11;
    resp_ready = 1'b1;
    #1;
    check("cont_first_grant", 64'(req_ready), 64'b01);
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cont%0d_resp_valid", i), 64'(resp_valid), 64'd1);
      check($sformatf("cont%0d_resp_id", i), 64'(resp_id), 64'(i % 2));
      check($sformatf("cont%0d_result", i), resp_result, (i % 2) ? 64'd22 : 64'd11);
      check($sformatf("cont%0d_req_ready", i), 64'(req_ready), (i % 2) ? 64'b01 : 64'b10);
      tick();
    end
    req_valid = 2'b00;
    tick();
    check("cont_drain_idle", 64'(resp_valid), 64'd0);

    // Backpressure: 546-7 held for three stalled cycles while req1 waits.
    set_req(0, ALU_SUB, 64'd546, 64'd7);
    req_valid  = 2'b01;
    resp_ready = 1'b1;
    #1;
    check("bp_grant0", 64'(req_ready), 64'b01);
    tick();
    set_req(1, ALU_ADD, 64'd100, 64'd5);
    req_valid  = 2'b10;
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp%0d_resp_valid", i), 64'(resp_valid), 64'd1);
      check($sformatf("bp%0d_result", i), resp_result, 64'd539);
      check($sformatf("bp%0d_resp_id", i), 64'(resp_id), 64'd0);
      check($sformatf("bp%0d_req_ready", i), 64'(req_ready), 64'd0);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    check("bp_release_grant", 64'(req_ready), 64'b10);
    tick();
    req_valid = 2'b00;
    #1;
    check("bp_next_valid", 64'(resp_valid), 64'd1);
    check("bp_next_id", 64'(resp_id), 64'd1);
    check("bp_next_result", resp_result, 64'd105);
    tick();

    // Reset mid-operation: req0 accepted (rr_ptr -> 1), response stalled, then reset.
    set_req(0, ALU_ADD, 64'd2, 64'd2);
    req_valid  = 2'b01;
    resp_ready = 1'b1;
    #1;
    check("rmid_grant0", 64'(req_ready), 64'b01);
    tick();
    req_valid  = 2'b00;
    resp_ready = 1'b0;
    #1;
    check("rmid_held_result", resp_result, 64'd4);
    rst       = 1'b1;
    req_valid = 2'b11;
    #1;
    check("rmid_resp_valid", 64'(resp_valid), 64'd0);
    check("rmid_resp_result", resp_result, 64'd0);
    check("rmid_resp_id", 64'(resp_id), 64'd0);
    check("rmid_req_ready", 64'(req_ready), 64'd0);
    check("rmid_cc_out", 64'(cc_out), CcEn ? 64'h4 : 64'h0);
    @(negedge clk);
    rst        = 1'b0;
    resp_ready = 1'b1;
    set_req(0, ALU_ADD, 64'd5, 64'd5);
    set_req(1, ALU_SUB, 64'd9, 64'd9);
    #1;
    check("rmid_rr_reset_grant", 64'(req_ready), 64'b01);
    req_valid = 2'b10;
    #1;
    check("rmid_req1_grant", 64'(req_ready), 64'b10);
    tick();
    req_valid = 2'b00;
    #1;
    check("rmid_req1_id", 64'(resp_id), 64'd1);
    check("rmid_req1_result", resp_result, 64'd0);
    check("rmid_req1_zf", 64'(resp_zf), 64'd1);
    check("rmid_req1_cc_kept", 64'(cc_out), CcEn ? 64'h4 : 64'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Arbitrates one shared 64-bit Y86 ALU (add/sub/and/xor) between NREQ requesters, for example the execute stage and the address-generation path.
- Round-robin grant, valid/ready request handshake, and a registered response with Y86 condition flags (ZF, SF, OF).
- Sits in the execute stage in front of the integer datapath.
- Only one operation is outstanding at a time.
- Back-to-back throughput is 1 op/cycle while the consumer keeps resp_ready high.

Parameters:
- DATA_W, 64, operand/result width
- NREQ, 2, number of requesters (2..4)
- ID_W, 2, width of resp_id; must satisfy 2^ID_W >= NREQ

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester grant/accept; at most one bit set
- req_op  in  2*NREQ  Y86 ifun per requester: 0 add, 1 sub, 2 and, 3 xor
- req_a  in  DATA_W*NREQ  operand A per requester, flattened, requester 0 in LSBs
- req_b  in  DATA_W*NREQ  operand B per requester, flattened
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts response
- resp_id  out  ID_W  index of the requester whose result this is
- resp_result  out  DATA_W  ALU result
- resp_zf  out  1  result == 0
- resp_sf  out  1  result[DATA_W-1]
- resp_of  out  1  signed overflow
- cc_out  out  3  {ZF,SF,OF} architectural condition codes (see Optional Feature)

Behaviour:
- Reset (async, immediate):
  - state = IDLE, rr_ptr = 0, resp_valid = 0.
  - resp_id, resp_result and all flags = 0; cc_out = 3'b100 (ZF=1).
  - req_ready = 0 while rst is high.
- FSM states:
  - IDLE: no response held.
  - RESP: response held on outputs.
- Accept window (can_accept):
  - can_accept = (state == IDLE) or (state == RESP and resp_ready).
- Grant:
  - Computed combinationally when can_accept.
  - Winner is the first i with req_valid[i] = 1, searching from rr_ptr upward with modulo-NREQ wrap.
  - req_ready[winner] = 1; all other bits 0.
  - req_ready never depends on resp_valid of another path.
  - req_ready is 0 in RESP unless resp_ready is high.
- Accept (req_valid & req_ready on the winner):
  - At the clock edge: resp_result and flags registered from the ALU on the winner's muxed operands; resp_id = winner; resp_valid = 1; state goes to RESP.
  - rr_ptr = (winner + 1) mod NREQ.
  - Latency: response visible the cycle after accept.
- RESP with resp_ready = 1 and no accept: resp_valid = 0, state goes to IDLE.
- RESP with resp_ready = 1 and a new accept in the same cycle: the new result replaces the old one; state stays RESP.
- RESP with resp_ready = 0:
  - All resp_* outputs stay stable.
  - No grants; rr_ptr is unchanged.
- Requester protocol: a requester must hold req_valid and its operands stable until accepted. Dropping req_valid before accept is allowed and has no effect.
- ALU arithmetic:
  - All operations are DATA_W-bit modular; the carry out is discarded.
  - add: r = a + b; OF = (a[msb] == b[msb]) & (r[msb] != a[msb]).
  - sub: r = a - b; OF = (a[msb] != b[msb]) & (r[msb] != a[msb]).
  - and / xor: OF = 0.
- Idle cycles: none required between operations.
- Fairness: no requester starves; a continuously asserting requester waits at most NREQ-1 grants.
- Reset mid-operation: the pending response is discarded, and all outputs return to their reset values asynchronously.

Optional Feature:
- Macro: ALU_SHARE_CC_REG_EN.
- Defined:
  - cc_out is a register updated with {ZF,SF,OF} on every accept from requester 0 only (architectural CC update by the execute stage).
  - Accepts from other requesters never change cc_out.
  - cc_out reset value is 3'b100.
- Undefined: no CC register is synthesised, and cc_out is tied to 3'b000.

Decomposition:
- Shared package alu_share_pkg holds:
  - the ALU op encoding constants ALU_ADD=2'd0, ALU_SUB=2'd1, ALU_AND=2'd2, ALU_XOR=2'd3;
  - the FSM state encoding;
  - the CC bit-index constants.
- Sub-module alu64: purely combinational (a, b, op) -> (result, zf, sf, of), instantiated once.
- The arbiter, FSM, response registers and optional CC register live in alu_share_arb.

Test Plan:
- Single add: req0 a=1, b=3, op=add, resp_ready=1 -> next cycle resp_valid=1, resp_id=0, result=4, zf/sf/of = 0/0/0.
- Sub overflow:
  - Stimulus: req1 a=64'h7FFF_FFFF_FFFF_FFFF, b=64'hFFFF_FFFF_FFFF_FFFE (-2), op=sub.
  - Required: result=64'h8000_0000_0000_0001, of=1, sf=1, resp_id=1.
- Contention:
  - Stimulus: req0 and req1 both valid continuously from reset, resp_ready=1.
  - Required: grants alternate 0,1,0,1; results come out back-to-back every cycle with no idle cycle.
- Backpressure:
  - Stimulus: resp_ready=0 for 3 cycles after an accept of 546-7.
  - Required: result=539 held stable, req_ready=0 throughout; resp_ready=1 then accepts the next request in that same cycle.
- Zero flag / logic ops:
  - xor a=b=64'hDEAD_BEEF -> zf=1, of=0.
  - and a=64'hF0, b=64'h0F -> result=0, zf=1.
- Reset mid-operation:
  - Stimulus: assert rst in RESP with resp_ready=0.
  - Required: resp_valid drops immediately; after release rr_ptr=0, so req0 wins against req1. With ALU_SHARE_CC_REG_EN, cc_out=3'b100 after reset and is unchanged by req1 ops.
